// File: rtl/tile_viewport_scanner_pkg.sv
// Shared definitions for the tile viewport scanner: scan-order encoding,
// FSM state encoding and the default coordinate width.
package scanner_pkg;

    localparam int DEFAULT_CNT_W = 16;

    localparam logic SCAN_RASTER = 1'b0;
    localparam logic SCAN_TILED  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/tile_viewport_scanner_if.sv
// Fragment coordinate stream: valid/ready handshake carrying (x,y) and
// the sof/eol/eof sideband flags.
interface tile_viewport_scanner_if
    import scanner_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] uv_x;
    logic [CNT_W-1:0] uv_y;
    logic             sof;
    logic             eol;
    logic             eof;

    modport master (
        output out_valid, uv_x, uv_y, sof, eol, eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, uv_x, uv_y, sof, eol, eof,
        output out_ready
    );
endinterface

// File: rtl/tile_viewport_scanner_wrap_counter.sv
// Step counter that wraps to zero on reaching a runtime limit; carry is
// asserted in the enabled cycle that produces the wrap.
module scan_wrap_counter
    import scanner_pkg::*;
#(
    parameter int W    = DEFAULT_CNT_W,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] q,
    output logic         carry
);
    // One extra bit so q + STEP cannot alias onto a small limit.
    logic [W:0] sum;

    assign sum   = {1'b0, q} + (W+1)'(STEP);
    assign carry = en && (sum == {1'b0, limit});

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= carry ? '0 : sum[W-1:0];
        end
    end
endmodule

// File: rtl/tile_viewport_scanner.sv
// Frame scanner emitting fragment coordinates in raster or tile-major order.
// Define TILE_VIEWPORT_SCANNER_CONTINUOUS_EN to loop frames back-to-back.
module tile_viewport_scanner
    import scanner_pkg::*;
#(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720,
    parameter int TILE_W = 32,
    parameter int TILE_H = 8,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic mode,
    output logic busy,
    output logic done,
    tile_viewport_scanner_if.master strm
);
    localparam logic [CNT_W-1:0] H_LIM   = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_LIM   = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] TW_LIM  = CNT_W'(TILE_W);
    localparam logic [CNT_W-1:0] TH_LIM  = CNT_W'(TILE_H);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_DISP - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_DISP - 1);
    localparam logic [CNT_W-1:0] TW_LAST = CNT_W'(TILE_W - 1);
    localparam logic [CNT_W-1:0] TH_LAST = CNT_W'(TILE_H - 1);

    scan_state_t      state;
    logic             mode_q;
    logic             tiled;
    logic             accept_start;
    logic             adv;
    logic             frame_end;
    logic [CNT_W-1:0] ox, oy, tbx, tby;
    logic             ox_carry, oy_carry, tbx_carry, tby_carry;
    logic [CNT_W-1:0] ox_lim, oy_lim;
    logic [CNT_W-1:0] px, py;

    assign tiled        = (mode_q == SCAN_TILED);
    assign accept_start = (state == ST_IDLE) && start;
    assign adv          = strm.out_valid && strm.out_ready;

    // In raster order ox/oy are the plain x/y counters over the whole frame.
    assign ox_lim = tiled ? TW_LIM : H_LIM;
    assign oy_lim = tiled ? TH_LIM : V_LIM;

    scan_wrap_counter #(.W(CNT_W), .STEP(1)) u_ox (
        .clk(clk), .rst(rst), .clr(accept_start), .en(adv),
        .limit(ox_lim), .q(ox), .carry(ox_carry)
    );

    scan_wrap_counter #(.W(CNT_W), .STEP(1)) u_oy (
        .clk(clk), .rst(rst), .clr(accept_start), .en(ox_carry),
        .limit(oy_lim), .q(oy), .carry(oy_carry)
    );

    scan_wrap_counter #(.W(CNT_W), .STEP(TILE_W)) u_tbx (
        .clk(clk), .rst(rst), .clr(accept_start), .en(tiled && oy_carry),
        .limit(H_LIM), .q(tbx), .carry(tbx_carry)
    );

    scan_wrap_counter #(.W(CNT_W), .STEP(TILE_H)) u_tby (
        .clk(clk), .rst(rst), .clr(accept_start), .en(tbx_carry),
        .limit(V_LIM), .q(tby), .carry(tby_carry)
    );

    // The outermost carry of the active chain marks the accepted last pixel.
    assign frame_end = tiled ? tby_carry : oy_carry;

    always_comb begin
        px = tiled ? (tbx + ox) : ox;
        py = tiled ? (tby + oy) : oy;
    end

    // Outputs depend only on registered state, never on out_ready.
    assign strm.uv_x = px;
    assign strm.uv_y = py;
    assign strm.sof  = strm.out_valid && (px == '0) && (py == '0);
    assign strm.eof  = strm.out_valid && (px == H_LAST) && (py == V_LAST);
    assign strm.eol  = strm.out_valid &&
                       (tiled ? ((ox == TW_LAST) && (oy == TH_LAST)) : (ox == H_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            mode_q         <= SCAN_RASTER;
            strm.out_valid <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state          <= ST_SCAN;
                        mode_q         <= mode;
                        strm.out_valid <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (frame_end) begin
                        done <= 1'b1;
`ifdef TILE_VIEWPORT_SCANNER_CONTINUOUS_EN
                        // Counters have all wrapped to zero; next frame starts without a bubble.
                        mode_q <= mode;
`else
                        state          <= ST_FIN;
                        strm.out_valid <= 1'b0;
`endif
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state          <= ST_IDLE;
                    strm.out_valid <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tile_viewport_scanner.sv
// Randomised bench for tile_viewport_scanner on an 8x4 frame with 4x2 tiles,
// checked every cycle against a frame-order reference model.
module tb_tile_viewport_scanner;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int TW = 4;
    localparam int TH = 2;
    localparam int CW = 16;
    localparam int N  = H * V;

    logic clk;
    logic rst;
    logic start;
    logic mode;
    logic rdy;
    logic busy;
    logic done;

    int n_chk  = 0;
    int n_fail = 0;

    tile_viewport_scanner_if #(.CNT_W(CW)) bus ();
    assign bus.out_ready = rdy;

    tile_viewport_scanner #(
        .H_DISP(H), .V_DISP(V), .TILE_W(TW), .TILE_H(TH), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done), .strm(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Pixel number i of a frame, straight from the scan-order definition.
    function automatic void pix(input logic md, input int i, output int x, output int y);
        int t, r;
        if (md == 1'b0) begin
            x = i % H;
            y = i / H;
        end else begin
            t = i / (TW * TH);
            r = i % (TW * TH);
            x = (t % (H / TW)) * TW + (r % TW);
            y = (t / (H / TW)) * TH + (r / TW);
        end
    endfunction

    function automatic logic eol_exp(input logic md, input int i);
        if (md == 1'b0) return (i % H) == H - 1;
        return (i % (TW * TH)) == TW * TH - 1;
    endfunction

    // Reference model: phase 0 idle, 1 scanning, 2 finishing.
    int   ph = 0;
    int   idx = 0;
    logic m_mode = 1'b0;
    logic m_done = 1'b0;
    bit   m_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ph     <= 0;
            idx    <= 0;
            m_mode <= 1'b0;
            m_done <= 1'b0;
            m_live <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (ph == 0) begin
                if (start) begin
                    ph     <= 1;
                    idx    <= 0;
                    m_mode <= mode;
                end
            end else if (ph == 1) begin
                if (rdy) begin
                    if (idx == N - 1) begin
                        m_done <= 1'b1;
                        idx    <= 0;
`ifdef TILE_VIEWPORT_SCANNER_CONTINUOUS_EN
                        m_mode <= mode;
`else
                        ph     <= 2;
`endif
                    end else begin
                        idx <= idx + 1;
                    end
                end
            end else begin
                ph <= 0;
            end
        end
    end

    int   hs_cnt = 0;
    int   hs_base = 0;
    bit   prev_stall = 1'b0;
    logic [CW-1:0] prev_x, prev_y;
    logic [2:0] prev_flags;

    always @(negedge clk) begin
        int ex, ey;
        if (m_live) begin
            chk("valid", bus.out_valid, ph == 1);
            chk("busy", busy, ph != 0);
            chk("done", done, m_done);
            if (ph == 1) begin
                pix(m_mode, idx, ex, ey);
                chk("uv_x", bus.uv_x, ex);
                chk("uv_y", bus.uv_y, ey);
                chk("sof", bus.sof, idx == 0);
                chk("eol", bus.eol, eol_exp(m_mode, idx));
                chk("eof", bus.eof, idx == N - 1);
            end
            if (done) begin
                chk("frame_beats", hs_cnt - hs_base, N);
                hs_base = hs_cnt;
            end
            if (prev_stall) begin
                chk("hold_x", bus.uv_x, prev_x);
                chk("hold_y", bus.uv_y, prev_y);
                chk("hold_flags", {bus.sof, bus.eol, bus.eof}, prev_flags);
            end
            prev_stall = bus.out_valid && !rdy && !rst;
            prev_x     = bus.uv_x;
            prev_y     = bus.uv_y;
            prev_flags = {bus.sof, bus.eol, bus.eof};
            if (rst) hs_base = hs_cnt;
            else if (bus.out_valid && rdy) hs_cnt++;
        end
    end

    task automatic run_frame(input logic md, input int pct, input bit poke);
        bit seen;
        seen  = 1'b0;
        start = 1'b1;
        mode  = md;
        rdy   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            rdy = ($urandom_range(0, 99) < pct);
            if (poke) begin
                start = 1'($urandom_range(0, 1));
                mode  = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        rdy   = 1'b1;
        chk("frame_completes", seen, 1);
        if (seen) begin
`ifdef TILE_VIEWPORT_SCANNER_CONTINUOUS_EN
            chk("cont_next_frame", {bus.out_valid, bus.sof, bus.uv_x, bus.uv_y}, {2'b11, 32'd0});
`else
            chk("fin_cycle", {bus.out_valid, busy}, 2'b01);
`endif
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic abort_test();
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b1;
        mode  = 1'b1;
        rdy   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart_first", {bus.out_valid, bus.sof, bus.uv_x, bus.uv_y}, {2'b11, 32'd0});
        repeat (10) @(posedge clk);
        #1;
        chk("beat10_x", bus.uv_x, 6);
        chk("beat10_y", bus.uv_y, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_state", {bus.out_valid, busy, done}, 3'b000);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int x, y;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        rdy   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {bus.out_valid, busy, done, bus.sof, bus.eol, bus.eof}, 6'b0);
        chk("rst_coords", {bus.uv_x, bus.uv_y}, 32'd0);
        rst = 1'b0;

        pix(1'b1, 4, x, y);  chk("model_tiled_4", {x[15:0], y[15:0]}, {16'd0, 16'd1});
        pix(1'b1, 8, x, y);  chk("model_tiled_8", {x[15:0], y[15:0]}, {16'd4, 16'd0});
        pix(1'b1, 31, x, y); chk("model_tiled_31", {x[15:0], y[15:0]}, {16'd7, 16'd3});
        pix(1'b0, 9, x, y);  chk("model_raster_9", {x[15:0], y[15:0]}, {16'd1, 16'd1});
        chk("model_eol_tiled", {eol_exp(1'b1, 7), eol_exp(1'b1, 6), eol_exp(1'b1, 15)}, 3'b101);
        chk("model_eol_raster", {eol_exp(1'b0, 7), eol_exp(1'b0, 8)}, 2'b10);

        run_frame(1'b0, 100, 1'b0);
        run_frame(1'b1, 100, 1'b0);
        run_frame(1'b1, 50, 1'b0);
        run_frame(1'b0, 50, 1'b1);
        run_frame(1'b1, 50, 1'b1);
        abort_test();
        run_frame(1'b0, 100, 1'b0);
        run_frame(1'b1, 70, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
